cache_bus_arbiter: RTL and testbench

CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

---
 rtl/cache_arb_pkg.sv | 34 +++
 rtl/cache_def.sv | 9 +
 rtl/cache_arb_timer.sv | 47 ++++
 rtl/cache_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_cache_bus_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_arb_pkg.sv
// Types and defaults for the cache bus arbiter.
// Holds the arbiter state enum, the port-owner enum and the default
// memory timeout, plus the round-robin winner selection rule.
package cache_arb_pkg;

    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    // On a tie the port that did not win last time gets the bus; a lone
    // request always wins. With no request the result is unused.
    function automatic owner_e pick_winner(input logic iReq,
                                           input logic dReq,
                                           input owner_e lastGrant);
        if (iReq && dReq) begin
            return (lastGrant == OWN_I) ? OWN_D : OWN_I;
        end else if (dReq) begin
            return OWN_D;
        end else begin
            return OWN_I;
        end
    endfunction

endpackage

// File: rtl/cache_def.sv
// Shared cache-side bus widths.
// Every block that touches the cache miss bus takes its address and data
// widths from here so the caches, arbiter and memory all agree.
package cache_def;

    localparam int CADDR_W = 32;
    localparam int CDATA_W = 32;

endpackage

// File: rtl/cache_arb_timer.sv
// Timeout counter for the cache bus arbiter.
// Ports:
//   clk      - clock, counts on the rising edge
//   rst      - asynchronous active-low reset, count returns to 0
//   clear_i  - synchronous clear, wins over enable
//   enable_i - advance the count by one
//   done_o   - terminal count reached (count == TIMEOUT-1)
module cache_arb_timer
    import cache_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic done_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Counting stops at the terminal value, so the counter can never wrap
    // even if the enable is left high.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !done_o) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == LAST);

endmodule

// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter between the instruction and data cache miss ports
// and a single memory port, one transaction at a time.
// Ports:
//   clk, rst                        - clock, asynchronous active-low reset
//   I_/D_strobe, _address, _rw,     - cache miss requests (rw 1 = read)
//   I_/D_wdata
//   I_/D_rdata, _ready, _err        - completion pulse to the owning port
//   M_strobe, M_address, M_rw,      - one-cycle memory command, fields held
//   M_wdata                           until the transaction completes
//   M_rdata, M_ready                - memory completion
module cache_bus_arbiter
    import cache_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int ADDR_W  = cache_def::CADDR_W,
    parameter int DATA_W  = cache_def::CDATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_strobe,
    input  logic [ADDR_W-1:0] I_address,
    input  logic              I_rw,
    input  logic [DATA_W-1:0] I_wdata,
    output logic [DATA_W-1:0] I_rdata,
    output logic              I_ready,
    output logic              I_err,
    input  logic              D_strobe,
    input  logic [ADDR_W-1:0] D_address,
    input  logic              D_rw,
    input  logic [DATA_W-1:0] D_wdata,
    output logic [DATA_W-1:0] D_rdata,
    output logic              D_ready,
    output logic              D_err,
    output logic              M_strobe,
    output logic [ADDR_W-1:0] M_address,
    output logic              M_rw,
    output logic [DATA_W-1:0] M_wdata,
    input  logic [DATA_W-1:0] M_rdata,
    input  logic              M_ready
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            lastGrant_q, lastGrant_d;
    owner_e            winner;
    logic              grant;
    logic              timerDone;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    cache_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q == ISSUE),
        .enable_i (state_q == WAIT),
        .done_o   (timerDone)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // M_ready only matters in WAIT; it is ignored in ISSUE, RESP and IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (I_strobe || D_strobe) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (M_ready || timerDone) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command fields and owner are loaded only on a grant, so the memory
    // side sees them stable for the whole transaction. A real response
    // takes priority over a timeout landing in the same cycle.
    always_comb begin
        grant       = (state_q == IDLE) && (I_strobe || D_strobe);
        winner      = pick_winner(I_strobe, D_strobe, lastGrant_q);
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        if (grant) begin
            owner_d     = winner;
            lastGrant_d = winner;
            addr_d      = (winner == OWN_I) ? I_address : D_address;
            rw_d        = (winner == OWN_I) ? I_rw      : D_rw;
            wdata_d     = (winner == OWN_I) ? I_wdata   : D_wdata;
        end
        if (state_q == WAIT) begin
            if (M_ready) begin
                rdata_d = rw_q ? M_rdata : '0;
                err_d   = 1'b0;
            end else if (timerDone) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q     <= OWN_I;
            lastGrant_q <= OWN_D;
            addr_q      <= '0;
            rw_q        <= 1'b1;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Completion is shown only on the owning port; the other port stays 0.
    always_comb begin
        M_strobe  = (state_q == ISSUE);
        M_address = addr_q;
        M_rw      = rw_q;
        M_wdata   = wdata_q;
        I_ready   = (state_q == RESP) && (owner_q == OWN_I);
        D_ready   = (state_q == RESP) && (owner_q == OWN_D);
        I_err     = I_ready && err_q;
        D_err     = D_ready && err_q;
        I_rdata   = I_ready ? rdata_q : '0;
        D_rdata   = D_ready ? rdata_q : '0;
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: directed scenarios followed by
// randomized request mixes compared against a transaction-level model.
module tb_cache_bus_arbiter;

    localparam int TIMEOUT = 16;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          I_strobe, I_rw, I_ready, I_err;
    logic [AW-1:0] I_address;
    logic [DW-1:0] I_wdata, I_rdata;
    logic          D_strobe, D_rw, D_ready, D_err;
    logic [AW-1:0] D_address;
    logic [DW-1:0] D_wdata, D_rdata;
    logic          M_strobe, M_rw, M_ready;
    logic [AW-1:0] M_address;
    logic [DW-1:0] M_wdata, M_rdata;

    int checks = 0;
    int errors = 0;

    // Observations of the most recent transaction, relative to its start.
    int            obMCyc;
    int            obMCount;
    int            obReadyCyc;
    logic [1:0]    obWho;
    logic [DW-1:0] obRdata;
    logic          obErr;
    logic [AW-1:0] obAddr;
    logic          obRw;
    logic [DW-1:0] obWdata;
    logic          obHoldOk;
    logic          obClean;
    bit            expLastI;

    cache_bus_arbiter #(
        .TIMEOUT (TIMEOUT),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .I_strobe  (I_strobe),
        .I_address (I_address),
        .I_rw      (I_rw),
        .I_wdata   (I_wdata),
        .I_rdata   (I_rdata),
        .I_ready   (I_ready),
        .I_err     (I_err),
        .D_strobe  (D_strobe),
        .D_address (D_address),
        .D_rw      (D_rw),
        .D_wdata   (D_wdata),
        .D_rdata   (D_rdata),
        .D_ready   (D_ready),
        .D_err     (D_err),
        .M_strobe  (M_strobe),
        .M_address (M_address),
        .M_rw      (M_rw),
        .M_wdata   (M_wdata),
        .M_rdata   (M_rdata),
        .M_ready   (M_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            M_ready = 1'b0;
        end
    endtask

    // Acts as the memory and records what the arbiter did until the first
    // ready pulse. lat = cycles from M_strobe to M_ready (0 = never).
    task automatic do_txn(input bit setI, input bit setD, input int lat,
                          input logic [DW-1:0] mdata, input bit dropMid,
                          input bit pulseIssue);
        obMCyc = -1; obMCount = 0; obReadyCyc = -1; obWho = 2'b00;
        obRdata = '0; obErr = 1'b0; obAddr = '0; obRw = 1'b0; obWdata = '0;
        obHoldOk = 1'b1; obClean = 1'b1;
        if (setI) I_strobe = 1'b1;
        if (setD) D_strobe = 1'b1;
        for (int n = 1; n <= TIMEOUT + 12; n++) begin
            tick();
            M_ready = 1'b0;
            if (M_strobe) begin
                obMCount++;
                if (obMCyc < 0) begin
                    obMCyc = n; obAddr = M_address; obRw = M_rw; obWdata = M_wdata;
                end
            end else if (obMCyc >= 0) begin
                if (M_address !== obAddr || M_rw !== obRw || M_wdata !== obWdata)
                    obHoldOk = 1'b0;
            end
            if (I_ready && D_ready) obClean = 1'b0;
            if (!I_ready && (I_err || I_rdata !== '0)) obClean = 1'b0;
            if (!D_ready && (D_err || D_rdata !== '0)) obClean = 1'b0;
            if (obMCyc >= 0) begin
                if (pulseIssue && n == obMCyc) begin
                    M_ready = 1'b1; M_rdata = ~mdata;
                end
                if (lat > 0 && n == obMCyc + lat) begin
                    M_ready = 1'b1; M_rdata = mdata;
                end
                if (dropMid && n == obMCyc + 1) I_strobe = 1'b0;
            end
            if (I_ready || D_ready) begin
                obReadyCyc = n;
                obWho   = {D_ready, I_ready};
                obRdata = I_ready ? I_rdata : D_rdata;
                obErr   = I_ready ? I_err : D_err;
                if (I_ready) I_strobe = 1'b0;
                if (D_ready) D_strobe = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; M_ready = 1'b0; M_rdata = '0;
        I_strobe = 1'b1; I_address = 32'h0000_0AA0; I_rw = 1'b0; I_wdata = 32'h5555_5555;
        D_strobe = 1'b1; D_address = 32'h0000_0BB0; D_rw = 1'b0; D_wdata = 32'h6666_6666;
        repeat (3) tick();
        checks++; if (M_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_mstrobe got=%0b exp=0", M_strobe); end
        checks++; if ({I_ready, D_ready, I_err, D_err} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready_err got=%b exp=0000", {I_ready, D_ready, I_err, D_err}); end
        checks++; if (I_rdata !== '0 || D_rdata !== '0) begin errors++; $display("[TB] FAIL reset_rdata got=%h/%h exp=0", I_rdata, D_rdata); end
        checks++; if (M_address !== '0) begin errors++; $display("[TB] FAIL reset_maddr got=%h exp=0", M_address); end
        checks++; if (M_wdata !== '0) begin errors++; $display("[TB] FAIL reset_mwdata got=%h exp=0", M_wdata); end
        checks++; if (M_rw !== 1'b1) begin errors++; $display("[TB] FAIL reset_mrw got=%0b exp=1", M_rw); end
        I_strobe = 1'b0; D_strobe = 1'b0; rst = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        I_address = 32'h0000_0110; I_rw = 1'b1; I_wdata = '0;
        D_address = 32'h0000_0210; D_rw = 1'b1; D_wdata = '0;
        do_txn(1, 1, 2, 32'h1111_0001, 0, 0);
        checks++; if (obWho !== 2'b01) begin errors++; $display("[TB] FAIL rr_first_owner got=%b exp=01", obWho); end
        checks++; if (obMCyc !== 1 || obReadyCyc !== 4) begin errors++; $display("[TB] FAIL rr_first_timing got=%0d/%0d exp=1/4", obMCyc, obReadyCyc); end
        checks++; if (obAddr !== 32'h0000_0110 || obRdata !== 32'h1111_0001) begin errors++; $display("[TB] FAIL rr_first_data got=%h/%h exp=110/11110001", obAddr, obRdata); end
        do_txn(1, 0, 1, 32'h2222_0002, 0, 0);
        checks++; if (obWho !== 2'b10) begin errors++; $display("[TB] FAIL rr_second_owner got=%b exp=10", obWho); end
        checks++; if (obMCyc !== 2) begin errors++; $display("[TB] FAIL rr_second_gap got=%0d exp=2", obMCyc); end
        checks++; if (obAddr !== 32'h0000_0210) begin errors++; $display("[TB] FAIL rr_second_addr got=%h exp=210", obAddr); end
        do_txn(0, 0, 1, 32'h3333_0003, 0, 0);
        checks++; if (obWho !== 2'b01 || obMCyc !== 2) begin errors++; $display("[TB] FAIL rr_third got=%b/%0d exp=01/2", obWho, obMCyc); end
        idle(2);
    endtask

    task automatic test_i_read();
        I_address = 32'h0000_0100; I_rw = 1'b1;
        do_txn(1, 0, 3, 32'hDEAD_BEEF, 0, 0);
        checks++; if (obWho !== 2'b01) begin errors++; $display("[TB] FAIL iread_owner got=%b exp=01", obWho); end
        checks++; if (obRdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL iread_rdata got=%h exp=deadbeef", obRdata); end
        checks++; if (obErr !== 1'b0) begin errors++; $display("[TB] FAIL iread_err got=%0b exp=0", obErr); end
        checks++; if (obMCyc !== 1 || obReadyCyc !== 5) begin errors++; $display("[TB] FAIL iread_latency got=%0d/%0d exp=1/5", obMCyc, obReadyCyc); end
        checks++; if (obAddr !== 32'h0000_0100 || obRw !== 1'b1) begin errors++; $display("[TB] FAIL iread_cmd got=%h/%0b exp=100/1", obAddr, obRw); end
        checks++; if (obMCount !== 1 || obClean !== 1'b1) begin errors++; $display("[TB] FAIL iread_clean got=%0d/%0b exp=1/1", obMCount, obClean); end
        idle(2);
    endtask

    task automatic test_d_write();
        D_address = 32'h0000_0200; D_rw = 1'b0; D_wdata = 32'h1234_5678;
        do_txn(0, 1, 4, 32'hFFFF_FFFF, 0, 0);
        checks++; if (obWho !== 2'b10) begin errors++; $display("[TB] FAIL dwrite_owner got=%b exp=10", obWho); end
        checks++; if (obRw !== 1'b0 || obAddr !== 32'h0000_0200 || obWdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL dwrite_cmd got=%0b/%h/%h exp=0/200/12345678", obRw, obAddr, obWdata); end
        checks++; if (obHoldOk !== 1'b1) begin errors++; $display("[TB] FAIL dwrite_hold got=%0b exp=1", obHoldOk); end
        checks++; if (obRdata !== '0 || obErr !== 1'b0) begin errors++; $display("[TB] FAIL dwrite_resp got=%h/%0b exp=0/0", obRdata, obErr); end
        checks++; if (obReadyCyc !== 6) begin errors++; $display("[TB] FAIL dwrite_latency got=%0d exp=6", obReadyCyc); end
        idle(2);
    endtask

    task automatic test_timeout();
        D_address = 32'h0000_02A0; D_rw = 1'b1; D_wdata = '0;
        do_txn(0, 1, 0, '0, 0, 0);
        checks++; if (obReadyCyc - obMCyc !== TIMEOUT + 1) begin errors++; $display("[TB] FAIL timeout_delay got=%0d exp=%0d", obReadyCyc - obMCyc, TIMEOUT + 1); end
        checks++; if (obWho !== 2'b10 || obErr !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err got=%b/%0b exp=10/1", obWho, obErr); end
        checks++; if (obRdata !== '0) begin errors++; $display("[TB] FAIL timeout_rdata got=%h exp=0", obRdata); end
        idle(2);
    endtask

    task automatic test_strobe_drop();
        int stray;
        I_address = 32'h0000_0180; I_rw = 1'b1;
        do_txn(1, 0, 4, 32'h5A5A_1234, 1, 0);
        checks++; if (obWho !== 2'b01 || obReadyCyc !== 6) begin errors++; $display("[TB] FAIL drop_ready got=%b/%0d exp=01/6", obWho, obReadyCyc); end
        checks++; if (obRdata !== 32'h5A5A_1234) begin errors++; $display("[TB] FAIL drop_rdata got=%h exp=5a5a1234", obRdata); end
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            M_ready = 1'b0;
            if (M_strobe || I_ready || D_ready) stray++;
        end
        checks++; if (obMCount + stray !== 1) begin errors++; $display("[TB] FAIL drop_no_reissue got=%0d exp=1", obMCount + stray); end
    endtask

    task automatic test_spurious_ready();
        int stray;
        stray = 0;
        M_ready = 1'b1; M_rdata = 32'h7777_7777;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (M_strobe || I_ready || D_ready) stray++;
        end
        M_ready = 1'b0;
        checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL idle_mready got=%0d exp=0", stray); end
        I_address = 32'h0000_0140; I_rw = 1'b1;
        do_txn(1, 0, 2, 32'hCAFE_0001, 0, 1);
        checks++; if (obReadyCyc !== 4) begin errors++; $display("[TB] FAIL issue_mready_time got=%0d exp=4", obReadyCyc); end
        checks++; if (obRdata !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL issue_mready_data got=%h exp=cafe0001", obRdata); end
        idle(2);
    endtask

    task automatic test_reset_mid();
        I_address = 32'h0000_0300; I_rw = 1'b1; I_wdata = 32'h0F0F_0F0F; I_strobe = 1'b1;
        tick();
        checks++; if (M_strobe !== 1'b1 || M_address !== 32'h0000_0300) begin errors++; $display("[TB] FAIL rmid_issue got=%0b/%h exp=1/300", M_strobe, M_address); end
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++; if (M_address !== '0 || M_wdata !== '0 || M_rw !== 1'b1 || M_strobe !== 1'b0) begin errors++; $display("[TB] FAIL rmid_outputs got=%h/%h/%0b/%0b exp=0/0/1/0", M_address, M_wdata, M_rw, M_strobe); end
        I_strobe = 1'b0;
        tick();
        M_ready = 1'b1; M_rdata = 32'hBAD0_BAD0;
        tick();
        checks++; if (I_ready !== 1'b0 || I_rdata !== '0) begin errors++; $display("[TB] FAIL rmid_late_ready got=%0b/%h exp=0/0", I_ready, I_rdata); end
        M_ready = 1'b0;
        I_address = 32'h0000_0400; I_rw = 1'b1;
        D_address = 32'h0000_0404; D_rw = 1'b0; D_wdata = 32'hA5A5_0000;
        rst = 1'b1;
        do_txn(1, 1, 2, 32'h4444_0004, 0, 0);
        checks++; if (obWho !== 2'b01 || obMCyc !== 1 || obReadyCyc !== 4) begin errors++; $display("[TB] FAIL rmid_after got=%b/%0d/%0d exp=01/1/4", obWho, obMCyc, obReadyCyc); end
        checks++; if (obRdata !== 32'h4444_0004 || obAddr !== 32'h0000_0400) begin errors++; $display("[TB] FAIL rmid_after_data got=%h/%h exp=44440004/400", obRdata, obAddr); end
        do_txn(0, 0, 1, 32'h9999_9999, 0, 0);
        checks++; if (obWho !== 2'b10 || obRw !== 1'b0 || obRdata !== '0) begin errors++; $display("[TB] FAIL rmid_after_d got=%b/%0b/%h exp=10/0/0", obWho, obRw, obRdata); end
        idle(2);
    endtask

    // Reference: each requester is served once, ties go to the port that
    // did not win last time, and a response either arrives within the
    // timeout window (lat 1..TIMEOUT) or the port gets an error after it.
    task automatic test_random();
        tick();
        #2; rst = 1'b0; tick(); rst = 1'b1;
        expLastI = 1'b0;
        for (int k = 0; k < 40; k++) begin
            int unsigned want;
            int nServe;
            bit firstI;
            want = $urandom_range(1, 3);
            I_address = $urandom; I_rw = 1'($urandom_range(0, 1)); I_wdata = $urandom;
            D_address = $urandom; D_rw = 1'($urandom_range(0, 1)); D_wdata = $urandom;
            nServe = (want == 3) ? 2 : 1;
            firstI = (want == 3) ? !expLastI : (want == 1);
            for (int s = 0; s < nServe; s++) begin
                bit ownI;
                bit ok;
                int lat;
                logic [DW-1:0] mdata;
                int expM;
                int expR;
                ownI = (s == 0) ? firstI : !firstI;
                lat = $urandom_range(0, TIMEOUT + 1);
                mdata = $urandom;
                ok = (lat >= 1 && lat <= TIMEOUT);
                expM = (s == 0) ? 1 : 2;
                expR = expM + (ok ? lat + 1 : TIMEOUT + 1);
                if (s == 0) do_txn(want[0], want[1], lat, mdata, 0, 1'($urandom_range(0, 1)));
                else        do_txn(0, 0, lat, mdata, 0, 1'($urandom_range(0, 1)));
                checks++; if (obWho !== (ownI ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL rnd_owner k=%0d got=%b exp=%b", k, obWho, ownI ? 2'b01 : 2'b10); end
                checks++; if (obMCyc !== expM || obReadyCyc !== expR) begin errors++; $display("[TB] FAIL rnd_timing k=%0d got=%0d/%0d exp=%0d/%0d", k, obMCyc, obReadyCyc, expM, expR); end
                checks++; if (obErr !== !ok) begin errors++; $display("[TB] FAIL rnd_err k=%0d got=%0b exp=%0b", k, obErr, !ok); end
                checks++; if (obRdata !== ((ok && (ownI ? I_rw : D_rw)) ? mdata : '0)) begin errors++; $display("[TB] FAIL rnd_rdata k=%0d got=%h exp=%h", k, obRdata, (ok && (ownI ? I_rw : D_rw)) ? mdata : '0); end
                checks++; if (obAddr !== (ownI ? I_address : D_address) || obRw !== (ownI ? I_rw : D_rw) || obWdata !== (ownI ? I_wdata : D_wdata)) begin errors++; $display("[TB] FAIL rnd_cmd k=%0d got=%h/%0b/%h", k, obAddr, obRw, obWdata); end
                checks++; if (obMCount !== 1 || obHoldOk !== 1'b1 || obClean !== 1'b1) begin errors++; $display("[TB] FAIL rnd_protocol k=%0d got=%0d/%0b/%0b exp=1/1/1", k, obMCount, obHoldOk, obClean); end
                expLastI = ownI;
            end
            idle($urandom_range(1, 3));
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_i_read();
        test_d_write();
        test_timeout();
        test_strobe_drop();
        test_spurious_ready();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
